// File: rtl/down_count_monitor.sv
// down_count_monitor
//   Downstream checker for a down counter. Each live sample must equal the
//   previous live sample minus one (mod 2^WIDTH). Counts accepted wraps and
//   sequence errors (both saturating) and parks in FAULT once the error count
//   reaches ERR_LIMIT, until clear_err or reset.
//   Optional build macro: DCM_HOLD_OK_EN -- a stalled (repeated) count is
//   accepted while locked instead of being flagged as an error.
module down_count_monitor #(
  parameter int WIDTH     = 4,
  parameter int WRAP_W    = 8,
  parameter int ERR_W     = 4,
  parameter int ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              q_valid,
  input  logic              clear_err,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic              err_sticky,
  output logic [WIDTH-1:0]  last_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    LOCK  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]  Q_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_LIM  = ERR_LIMIT[ERR_W-1:0];

  state_t           state;
  logic [WIDTH-1:0] exp_q;
  logic             match;
  logic             hold_ok;
  logic [ERR_W-1:0] err_inc;

  // Expected next sample; 0 - 1 naturally yields the all-ones wrap value.
  assign exp_q = last_q - Q_ONE;
  assign match = (q_in == exp_q);

`ifdef DCM_HOLD_OK_EN
  assign hold_ok = (q_in == last_q);
`else
  assign hold_ok = 1'b0;
`endif

  // Saturating successor of the error count.
  assign err_inc = (err_count == ERR_MAX) ? err_count : (err_count + ERR_ONE);

  // Monitor FSM with registered status outputs; clear_err is applied last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      err_sticky <= 1'b0;
      last_q     <= '0;
    end else begin
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      if (q_valid) begin
        // Every live sample becomes the reference for the next one, in all states.
        last_q <= q_in;
        case (state)
          IDLE: begin
            state  <= SYNC;
            locked <= 1'b0;
          end
          SYNC: begin
            if (match) begin
              state  <= LOCK;
              locked <= 1'b1;
            end else begin
              state  <= SYNC;
              locked <= 1'b0;
            end
          end
          LOCK: begin
            if (match) begin
              if (last_q == '0) begin
                wrap_pulse <= 1'b1;
                if (wrap_count != WRAP_MAX) begin
                  wrap_count <= wrap_count + WRAP_ONE;
                end
              end
            end else if (hold_ok) begin
              state <= LOCK;
            end else begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              err_count  <= err_inc;
              // A same-cycle clear leaves the count at zero, so no FAULT then.
              if (!clear_err && (err_inc >= ERR_LIM)) begin
                state <= FAULT;
              end else begin
                state <= SYNC;
              end
              locked <= 1'b0;
            end
          end
          FAULT: begin
            locked <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
      if (clear_err) begin
        err_count  <= '0;
        err_sticky <= 1'b0;
        if (state == FAULT) begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_count_monitor.sv
// Self-checking bench for down_count_monitor: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_down_count_monitor;

  localparam int WIDTH = 4;
  localparam int WRAP_W = 4;
  localparam int ERR_W = 4;
  localparam int ERR_LIMIT = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] q_in = '0;
  logic             q_valid = 1'b0;
  logic             clear_err = 1'b0;
  logic             locked;
  logic             wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             err_sticky;
  logic [WIDTH-1:0] last_q;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0=waiting for first sample, 1=seeking, 2=locked, 3=faulted
  int m_phase = 0;
  int m_last = 0;
  int m_wc = 0;
  int m_ec = 0;
  int m_st = 0;
  int m_wp = 0;
  int m_ep = 0;
  int cnt;

  down_count_monitor #(
    .WIDTH(WIDTH), .WRAP_W(WRAP_W), .ERR_W(ERR_W), .ERR_LIMIT(ERR_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .q_valid(q_valid),
    .clear_err(clear_err), .locked(locked), .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count), .err_pulse(err_pulse), .err_count(err_count),
    .err_sticky(err_sticky), .last_q(last_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Behavioural reference: apply one clock edge of the rules to the model.
  task automatic model_edge(input int r, input int v, input int q, input int c);
    int expect_q;
    int was_fault;
    int hold;
    m_wp = 0;
    m_ep = 0;
    if (r != 0) begin
      m_phase = 0; m_last = 0; m_wc = 0; m_ec = 0; m_st = 0;
      return;
    end
    expect_q = (m_last + 15) % 16;
    was_fault = (m_phase == 3);
`ifdef DCM_HOLD_OK_EN
    hold = (q == m_last);
`else
    hold = 0;
`endif
    if (v != 0) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (q == expect_q) m_phase = 2;
      end else if (m_phase == 2) begin
        if (q == expect_q) begin
          if (m_last == 0) begin
            m_wp = 1;
            if (m_wc < 15) m_wc++;
          end
        end else if (hold == 0) begin
          m_ep = 1;
          m_st = 1;
          if (m_ec < 15) m_ec++;
          m_phase = (c == 0 && m_ec >= ERR_LIMIT) ? 3 : 1;
        end
      end
      m_last = q;
    end
    if (c != 0) begin
      m_ec = 0;
      m_st = 0;
      if (was_fault != 0) m_phase = 0;
    end
  endtask

  task automatic step(input int r, input int v, input int q, input int c);
    @(negedge clk);
    reset = (r != 0);
    q_valid = (v != 0);
    q_in = q[WIDTH-1:0];
    clear_err = (c != 0);
    @(posedge clk);
    model_edge(r, v, q, c);
    #1;
    chk("locked", {31'd0, locked}, (m_phase == 2) ? 32'd1 : 32'd0);
    chk("wrap_pulse", {31'd0, wrap_pulse}, m_wp);
    chk("wrap_count", {28'd0, wrap_count}, m_wc);
    chk("err_pulse", {31'd0, err_pulse}, m_ep);
    chk("err_count", {28'd0, err_count}, m_ec);
    chk("err_sticky", {31'd0, err_sticky}, m_st);
    chk("last_q", {28'd0, last_q}, m_last);
  endtask

  initial begin
    // 1: reset for two cycles with no valid samples
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_last_q", {28'd0, last_q}, 32'd0);

    // 2: clean count through a wrap
    step(0, 1, 5, 0);
    step(0, 1, 4, 0);
    chk("t2_lock_after_4", {31'd0, locked}, 32'd1);
    step(0, 1, 3, 0);
    step(0, 1, 2, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 15, 0);
    chk("t2_wrap_pulse", {31'd0, wrap_pulse}, 32'd1);
    step(0, 1, 14, 0);
    chk("t2_wrap_count", {28'd0, wrap_count}, 32'd1);
    chk("t2_err_count", {28'd0, err_count}, 32'd0);

    // 3: single error at 9 -> 6, then relock
    for (int i = 13; i >= 9; i--) step(0, 1, i, 0);
    step(0, 1, 6, 0);
    chk("t3_err_pulse", {31'd0, err_pulse}, 32'd1);
    chk("t3_locked", {31'd0, locked}, 32'd0);
    step(0, 1, 5, 0);
    step(0, 1, 4, 0);
    chk("t3_relock", {31'd0, locked}, 32'd1);
    chk("t3_sticky", {31'd0, err_sticky}, 32'd1);

    // 4: reach ERR_LIMIT, good samples ignored in FAULT, clear and relock
    step(0, 1, 9, 0);
    step(0, 1, 8, 0);
    step(0, 1, 2, 0);
    chk("t4_err_count", {28'd0, err_count}, 32'd3);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    chk("t4_fault_unlocked", {31'd0, locked}, 32'd0);
    step(0, 0, 0, 1);
    chk("t4_clear_count", {28'd0, err_count}, 32'd0);
    chk("t4_clear_sticky", {31'd0, err_sticky}, 32'd0);
    step(0, 1, 15, 0);
    step(0, 1, 14, 0);
    chk("t4_relock", {31'd0, locked}, 32'd1);

    // 5: stalled counter at 7; q_valid=0 gaps must not break lock
    for (int i = 13; i >= 7; i--) begin
      step(0, 1, i, 0);
      step(0, 0, 3, 0);
    end
    step(0, 1, 7, 0);
`ifdef DCM_HOLD_OK_EN
    chk("t5_hold_err", {28'd0, err_count}, 32'd0);
    chk("t5_hold_locked", {31'd0, locked}, 32'd1);
`else
    chk("t5_hold_err", {28'd0, err_count}, 32'd1);
    chk("t5_hold_locked", {31'd0, locked}, 32'd0);
`endif

    // 6: bring wrap_count to 3, reset mid-lock, then saturate with 20 wraps
    step(0, 1, 6, 0);
    step(0, 1, 5, 0);
    cnt = 4;
    while (m_wc < 3) begin
      step(0, 1, cnt, 0);
      cnt = (cnt + 15) % 16;
    end
    chk("t6_wrap3", {28'd0, wrap_count}, 32'd3);
    step(1, 1, cnt, 1);
    chk("t6_rst_wrap", {28'd0, wrap_count}, 32'd0);
    chk("t6_rst_locked", {31'd0, locked}, 32'd0);
    cnt = 3;
    for (int i = 0; i < 20 * 16 + 4; i++) begin
      step(0, 1, cnt, 0);
      cnt = (cnt + 15) % 16;
    end
    chk("t6_wrap_sat", {28'd0, wrap_count}, 32'd15);

    // Randomized traffic: mostly a down count with glitches, stalls, gaps, clears, resets
    step(1, 0, 0, 0);
    cnt = $urandom_range(15, 0);
    for (int i = 0; i < 1500; i++) begin
      int sel;
      int v;
      int q;
      int c;
      int r;
      sel = $urandom_range(99, 0);
      v = ($urandom_range(99, 0) < 85) ? 1 : 0;
      c = ($urandom_range(99, 0) < 4) ? 1 : 0;
      r = ($urandom_range(999, 0) < 8) ? 1 : 0;
      if (sel < 8) q = $urandom_range(15, 0);
      else if (sel < 16) q = (cnt + 1) % 16;
      else q = cnt;
      step(r, v, q, c);
      if (v != 0) cnt = (q + 15) % 16;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
